// File: rtl/tomasulo_pkg.sv
// Shared CDB types: tag/data widths and the FU-result and broadcast records.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package tomasulo_pkg;

  localparam int TAG_W  = 7;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] wdata;
  } fu_result_t;

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] wdata;
  } cdb_t;

endpackage

// File: rtl/tomasulo_cdb_fifo.sv
// Per-FU in-order result buffer feeding the CDB arbiter.
// Latency: a push is visible at head/empty after the capturing edge (no bypass).
// Backpressure: full_r is registered; a push while full_r is dropped and flagged.
// Ports: clk/rst (async active-low); push/push_dat write side; pop removes head;
//        head/empty describe current state; empty_nxt is the post-edge emptiness.
module tomasulo_cdb_fifo
  import tomasulo_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fu_result_t push_dat,
  input  logic       pop,
  output fu_result_t head,
  output logic       empty,
  output logic       empty_nxt,
  output logic       full_r
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fu_result_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Illegal pushes (while full) are simply not accepted.
  assign push_ok   = push & ~full_r;
  assign pop_ok    = pop & ~empty;
  assign cnt_nxt   = cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign empty     = (cnt == '0);
  assign empty_nxt = (cnt_nxt == '0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full_r <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      cnt    <= cnt_nxt;
      full_r <= (cnt_nxt == CNT_W'(FIFO_DEPTH));
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push && full_r))
        else $warning("tomasulo_cdb_fifo: push while full dropped");
    end
  end

endmodule

// File: rtl/tomasulo_cdb_arb.sv
// Round-robin arbiter granting one buffered FU result per cycle onto the CDB.
// Latency: FU push captured at edge t+1, broadcast registered at edge t+2.
// Backpressure: per-FU registered fu_full_r; pushes while full are dropped.
// Ports: clk/rst (async active-low); fu_vld_r/fu_r per-FU result pushes;
//        fu_full_r per-FU buffer full; cdb_r registered broadcast; idle_r quiet.
module tomasulo_cdb_arb
  import tomasulo_pkg::*;
#(
  parameter int N_FU       = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_FU-1:0] fu_vld_r,
  input  fu_result_t      fu_r [N_FU],
  output logic [N_FU-1:0] fu_full_r,
  output cdb_t            cdb_r,
  output logic            idle_r
);

  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [N_FU-1:0]  empty;
  logic [N_FU-1:0]  empty_nxt;
  logic [N_FU-1:0]  pop;
  fu_result_t       head [N_FU];
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic             gnt_vld;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_FU) s = s - N_FU;
    return PTR_W'(s);
  endfunction

  for (genvar i = 0; i < N_FU; i++) begin : g_fifo
    tomasulo_cdb_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fu_vld_r[i]),
      .push_dat (fu_r[i]),
      .pop      (pop[i]),
      .head     (head[i]),
      .empty    (empty[i]),
      .empty_nxt(empty_nxt[i]),
      .full_r   (fu_full_r[i])
    );
    assign pop[i] = gnt_vld && (winner == PTR_W'(i));
  end

  // Requests come from registered occupancy only, so a push never wins in
  // its own cycle. Search starts at rr_ptr and wraps.
  always_comb begin
    gnt_vld = 1'b0;
    winner  = '0;
    for (int k = 0; k < N_FU; k++) begin
      if (!gnt_vld && !empty[wrap_add(rr_ptr, k)]) begin
        gnt_vld = 1'b1;
        winner  = wrap_add(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      cdb_r  <= '0;
      idle_r <= 1'b1;
    end else begin
      cdb_r.vld <= gnt_vld;
      if (gnt_vld) begin
        rr_ptr      <= wrap_add(winner, 1);
        cdb_r.tag   <= head[winner].tag;
        cdb_r.wdata <= head[winner].wdata;
      end
      idle_r <= (&empty_nxt) && !gnt_vld;
    end
  end

endmodule

// File: tb/tb_tomasulo_cdb_arb.sv
// Directed bench for tomasulo_cdb_arb with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
// Each check is an immediate assertion that counts and reports mismatches.
module tb_tomasulo_cdb_arb;
  import tomasulo_pkg::*;

  localparam int N_FU = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_FU-1:0] fu_vld_r;
  fu_result_t      fu_r [N_FU];
  logic [N_FU-1:0] fu_full_r;
  cdb_t            cdb_r;
  logic            idle_r;

  int checks = 0;
  int errors = 0;
  int p1 = 0;
  int p3 = 0;
  int exp_tag;

  always #5 clk = ~clk;

  tomasulo_cdb_arb #(
    .N_FU(N_FU),
    .FIFO_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fu_vld_r (fu_vld_r),
    .fu_r     (fu_r),
    .fu_full_r(fu_full_r),
    .cdb_r    (cdb_r),
    .idle_r   (idle_r)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
  endtask

  task automatic chk_bc(input string name, input int tag, input logic [31:0] wdata);
    chk({name, "_vld"}, 64'(cdb_r.vld), 64'd1);
    chk({name, "_tag"}, 64'(cdb_r.tag), 64'(tag));
    chk({name, "_wdata"}, 64'(cdb_r.wdata), 64'(wdata));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int fu, input int tag, input logic [31:0] wdata);
    fu_vld_r[fu]    = 1'b1;
    fu_r[fu].tag    = TAG_W'(tag);
    fu_r[fu].wdata  = wdata;
  endtask

  initial begin
    rst      = 1'b0;
    fu_vld_r = '0;
    for (int i = 0; i < N_FU; i++) fu_r[i] = '0;

    // Reset state
    tick();
    tick();
    chk("rst_vld", 64'(cdb_r.vld), 64'd0);
    chk("rst_tag", 64'(cdb_r.tag), 64'd0);
    chk("rst_wdata", 64'(cdb_r.wdata), 64'd0);
    chk("rst_full", 64'(fu_full_r), 64'd0);
    chk("rst_idle", 64'(idle_r), 64'd1);
    chk("rst_rr", 64'(dut.rr_ptr), 64'd0);
    rst = 1'b1;

    // Contention: all four FUs push together, rr_ptr=0 -> tags 1,2,3,4
    for (int i = 0; i < N_FU; i++) drive(i, i + 1, 32'h1000 + i + 1);
    tick();
    fu_vld_r = '0;
    chk("cont_cap_vld", 64'(cdb_r.vld), 64'd0);
    chk("cont_cap_idle", 64'(idle_r), 64'd0);
    chk("cont_cap_full", 64'(fu_full_r), 64'd0);
    for (int k = 0; k < N_FU; k++) begin
      tick();
      chk_bc($sformatf("cont_bc%0d", k), k + 1, 32'h1000 + k + 1);
    end
    chk("cont_rr", 64'(dut.rr_ptr), 64'd0);
    chk("cont_busy", 64'(idle_r), 64'd0);
    tick();
    chk("cont_end_vld", 64'(cdb_r.vld), 64'd0);
    chk("cont_end_hold", 64'(cdb_r.tag), 64'd4);
    chk("cont_end_idle", 64'(idle_r), 64'd1);

    // Single push: FU2 tag 5 / 0xDEAD
    drive(2, 5, 32'hDEAD);
    tick();
    fu_vld_r = '0;
    chk("single_e1_vld", 64'(cdb_r.vld), 64'd0);
    chk("single_e1_idle", 64'(idle_r), 64'd0);
    tick();
    chk_bc("single_e2", 5, 32'hDEAD);
    chk("single_e2_idle", 64'(idle_r), 64'd0);
    tick();
    chk("single_e3_vld", 64'(cdb_r.vld), 64'd0);
    chk("single_e3_hold_tag", 64'(cdb_r.tag), 64'd5);
    chk("single_e3_hold_wdata", 64'(cdb_r.wdata), 64'hDEAD);
    chk("single_e3_idle", 64'(idle_r), 64'd1);

    // Push and pop on the same edge at occupancy 1 (FU1 tags 9 then 10)
    drive(1, 9, 32'h1009);
    tick();
    drive(1, 10, 32'h100A);
    tick();
    fu_vld_r = '0;
    chk_bc("pp_bc9", 9, 32'h1009);
    chk("pp_full", 64'(fu_full_r), 64'd0);
    tick();
    chk_bc("pp_bc10", 10, 32'h100A);
    tick();
    chk("pp_end_vld", 64'(cdb_r.vld), 64'd0);
    chk("pp_end_idle", 64'(idle_r), 64'd1);

    // Rotation: FU1 and FU3 push whenever allowed; rr_ptr=2 so FU3 leads
    drive(1, 'h10 + p1, 32'h2000 + p1); p1++;
    drive(3, 'h30 + p3, 32'h3000 + p3); p3++;
    tick();
    for (int k = 0; k < 11; k++) begin
      fu_vld_r = '0;
      if (k < 8) begin
        if (!fu_full_r[1]) begin drive(1, 'h10 + p1, 32'h2000 + p1); p1++; end
        if (!fu_full_r[3]) begin drive(3, 'h30 + p3, 32'h3000 + p3); p3++; end
      end
      tick();
      if (k % 2 == 0) begin
        exp_tag = 'h30 + k / 2;
        chk_bc($sformatf("rot_bc%0d", k), exp_tag, 32'h3000 + k / 2);
      end else begin
        exp_tag = 'h10 + k / 2;
        chk_bc($sformatf("rot_bc%0d", k), exp_tag, 32'h2000 + k / 2);
      end
    end
    fu_vld_r = '0;
    tick();
    chk("rot_end_vld", 64'(cdb_r.vld), 64'd0);
    chk("rot_end_idle", 64'(idle_r), 64'd1);

    // Reset with 3 results buffered (rr_ptr=0)
    drive(0, 'h40, 32'h4040);
    drive(1, 'h41, 32'h4041);
    drive(3, 'h43, 32'h4043);
    tick();
    fu_vld_r = '0;
    drive(3, 'h44, 32'h4044);
    tick();
    fu_vld_r = '0;
    chk_bc("rstmid_bc", 'h40, 32'h4040);
    chk("rstmid_full", 64'(fu_full_r), 64'b1000);
    rst = 1'b0;
    #1;
    chk("rstmid_vld", 64'(cdb_r.vld), 64'd0);
    chk("rstmid_tag", 64'(cdb_r.tag), 64'd0);
    chk("rstmid_full_clr", 64'(fu_full_r), 64'd0);
    chk("rstmid_idle", 64'(idle_r), 64'd1);
    tick();
    tick();
    rst = 1'b1;
    // First push right after release, captured at the first edge
    drive(0, 'h3F, 32'h403F);
    tick();
    fu_vld_r = '0;
    chk("rel_e1_vld", 64'(cdb_r.vld), 64'd0);
    chk("rel_e1_idle", 64'(idle_r), 64'd0);
    tick();
    chk_bc("rel_bc", 'h3F, 32'h403F);
    tick();
    chk("rel_nostale_vld", 64'(cdb_r.vld), 64'd0);
    chk("rel_idle", 64'(idle_r), 64'd1);

    // Backpressure: rr_ptr=1, FU0 fills with 7,8 while FU1..3 win
    drive(0, 7, 32'h7007);
    drive(1, 'h11, 32'h5011);
    drive(2, 'h12, 32'h5012);
    drive(3, 'h13, 32'h5013);
    tick();
    fu_vld_r = '0;
    drive(0, 8, 32'h8008);
    tick();
    fu_vld_r = '0;
    chk_bc("bp_bc_fu1", 'h11, 32'h5011);
    chk("bp_full_set", 64'(fu_full_r), 64'b0001);
    drive(0, 9, 32'h9009);
    tick();
    fu_vld_r = '0;
    chk_bc("bp_bc_fu2", 'h12, 32'h5012);
    chk("bp_full_held", 64'(fu_full_r), 64'b0001);
    tick();
    chk_bc("bp_bc_fu3", 'h13, 32'h5013);
    tick();
    chk_bc("bp_bc_7", 7, 32'h7007);
    chk("bp_full_clr", 64'(fu_full_r), 64'd0);
    tick();
    chk_bc("bp_bc_8", 8, 32'h8008);
    tick();
    chk("bp_drop_vld", 64'(cdb_r.vld), 64'd0);
    chk("bp_end_idle", 64'(idle_r), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
